seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial pattern detector; next generation of the fixed 2-step a->b detector FSM.
//  Watches a stream of W-bit symbols qualified by in_valid.
//  Pulses match when the last N accepted symbols equal a runtime-programmable pattern.
//  Supports per-symbol don't-care masking, overlapping/non-overlapping mode and a saturating match counter.
//  Sits between a symbol source (decoder/UART-style front end) and control logic needing event triggers.
// PARAMETERS
//  W       2             symbol width in bits (1..8)
//  N       4             pattern length in symbols (2..8)
//  CW      8             match counter width
//  DEF_PAT 8'b00_11_10_01  reset pattern, N*W bits; symbol i = DEF_PAT[W*i +: W]; symbol 0 arrives first
// PORTS
//  clk         in   1    clock, all state on rising edge
//  reset_n     in   1    asynchronous active-low reset
//  cfg_we      in   1    load cfg_pattern/cfg_mask/cfg_overlap this cycle
//  cfg_pattern in   N*W  new pattern, same packing as DEF_PAT
//  cfg_mask    in   N    bit i = 1: symbol i must match; 0: symbol i is don't-care
//  cfg_overlap in   1    1 = overlapping matches allowed, 0 = history flushed after a match
//  in_valid    in   1    in_sym is accepted this cycle
//  in_sym      in   W    input symbol
//  clr_cnt     in   1    synchronous clear of match_cnt
//  match       out  1    registered 1-cycle pulse, pattern completed
//  match_cnt   out  CW   saturating count of matches
//  fill        out  4    accepted symbols held in history, 0..N (status)
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - pattern=DEF_PAT, mask=all ones, overlap=0
//   - history=0, fill=0, match=0, match_cnt=0
//  Accept: symbol taken only when in_valid=1 && cfg_we=0.
//   - in_valid=0 cycles neither break nor advance the sequence.
//  History: N-1 most recent accepted symbols in a shift register; fill increments per accept, saturates at N.
//  Hit: on an accepted symbol, (fill >= N-1) and for every i with mask[i]=1 the candidate equals pattern symbol i.
//   - candidate = oldest..newest history, then in_sym as symbol N-1.
//  Latency: match=1 in the cycle after the accepting edge, for exactly one cycle; otherwise 0.
//  On hit:
//   - overlap=1: fill stays N; next accept can hit again.
//   - overlap=0: fill <= 0 and history cleared; a full new pattern is needed.
//  Counter: match_cnt += 1 per hit, holds at 2^CW-1. clr_cnt in the same cycle as a hit: clear wins (cnt=0), match still pulses.
//  cfg_we=1:
//   - loads all three config fields
//   - flushes history (fill=0)
//   - a symbol with in_valid in the same cycle is dropped
//   - no hit is evaluated that cycle
//  mask all zeros: every accept with fill >= N-1 hits (legal, documented).
//  Mid-sequence reset: all state returns to reset values immediately, no pulse produced.
//  Internal FSM: IDLE (fill=0) -> FILL (0<fill<N) -> ARMED (fill=N).
//   - ARMED -> IDLE on non-overlap hit or cfg_we.
//   - any -> IDLE on reset.
// TESTING
//  1 Reset, default cfg, feed 1,2,3,0 valid back-to-back -> match=1 one cycle after the 4th symbol, match_cnt=1.
//  2 cfg pattern 1,1,1,1 mask 4'hF overlap=1, feed six 1s -> match after the 4th, 5th and 6th symbols, cnt=3.
//    Same with overlap=0: eight 1s -> match after the 4th and 8th only, cnt=2.
//  3 Default pattern, insert in_valid=0 gaps of 3 cycles between symbols -> single match after the 4th accepted symbol.
//  4 mask=4'b1101, pattern 1,x,3,0, feed 1,2,3,0 then 1,0,3,0 -> two matches. Feed 1,2,2,0 -> none.
//  5 CW=2: produce 5 hits -> cnt=3 and holds. clr_cnt coincident with a hit -> cnt=0, match=1.
//  6 Feed 1,2,3, drop reset_n for 1 cycle, feed 0 -> no match, fill=1.
//    cfg_we mid-stream with in_valid=1 -> symbol dropped, fill=0.

Source files
------------

// File: rtl/seq_detect_param.sv
// Purpose : parametrised serial pattern detector with masked symbols, overlap mode and match counter.
// Latency : match pulses one cycle after the edge that accepts the completing symbol.
// Backpr. : none; every in_valid symbol outside a cfg_we cycle is consumed, cfg_we cycles drop it.
//
// Ports:
//   clk, reset_n      clock (rising edge) and asynchronous active-low reset
//   cfg_we            loads cfg_pattern/cfg_mask/cfg_overlap and flushes the history
//   cfg_pattern       N*W bits, symbol i at [W*i +: W], symbol 0 is the oldest in the sequence
//   cfg_mask          bit i = 1 -> symbol i is compared, 0 -> don't-care
//   cfg_overlap       1 = keep history after a match, 0 = restart from an empty history
//   in_valid, in_sym  symbol stream
//   clr_cnt           synchronous clear of match_cnt (takes priority over an increment)
//   match             registered one-cycle pulse per detected pattern
//   match_cnt         saturating match count
//   fill              number of accepted symbols in the history (0..N)
module seq_detect_param #(
    parameter int unsigned W = 2,
    parameter int unsigned N = 4,
    parameter int unsigned CW = 8,
    parameter logic [N*W-1:0] DEF_PAT = 8'b00_11_10_01
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_we,
    input  logic [N*W-1:0]  cfg_pattern,
    input  logic [N-1:0]    cfg_mask,
    input  logic            cfg_overlap,
    input  logic            in_valid,
    input  logic [W-1:0]    in_sym,
    input  logic            clr_cnt,
    output logic            match,
    output logic [CW-1:0]   match_cnt,
    output logic [3:0]      fill
);

    localparam logic [3:0] FILL_MAX = 4'(N);
    localparam logic [3:0] FILL_ARM = 4'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N*W-1:0]         pat_q, pat_d;
    logic [N-1:0]           mask_q, mask_d;
    logic                   ovl_q, ovl_d;
    logic [(N-1)*W-1:0]     hist_q, hist_d;
    logic [3:0]             fill_q, fill_d;
    logic                   match_q, match_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   accept;
    logic [N*W-1:0]         cand;
    logic                   sym_ok;
    logic                   hit;

    always_comb begin
        accept = in_valid && !cfg_we;
        // History holds symbols 0..N-2 (oldest in the low bits); the incoming
        // symbol completes the candidate as symbol N-1.
        cand   = {in_sym, hist_q};

        sym_ok = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            if (mask_q[i] && (cand[W*i +: W] != pat_q[W*i +: W])) begin
                sym_ok = 1'b0;
            end
        end

        // A hit needs N-1 symbols already held: either fully armed, or one short.
        hit = accept && sym_ok && ((state_q == ARMED) || (fill_q == FILL_ARM));
    end

    always_comb begin
        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = hit;
        cnt_d   = cnt_q;
        state_d = state_q;

        if (cfg_we) begin
            pat_d  = cfg_pattern;
            mask_d = cfg_mask;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            if (hit && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                // Dropping the oldest symbol leaves exactly the upper N-1 candidate symbols.
                hist_d = cand[N*W-1:W];
                fill_d = (state_q == ARMED) ? FILL_MAX : fill_q + 4'd1;
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (fill_d == 4'd0) begin
            state_d = IDLE;
        end else if (fill_d == FILL_MAX) begin
            state_d = ARMED;
        end else begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pat_q   <= DEF_PAT;
            mask_q  <= {N{1'b1}};
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_mask;
    logic       cfg_overlap;
    logic       in_valid;
    logic [1:0] in_sym;
    logic       clr_cnt;
    logic       match;
    logic [7:0] match_cnt;
    logic [3:0] fill;
    logic       match2;
    logic [1:0] match_cnt2;
    logic [3:0] fill2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.W(2), .N(4), .CW(8), .DEF_PAT(8'b00_11_10_01)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_sym(in_sym), .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt),
        .fill(fill)
    );

    seq_detect_param #(.W(2), .N(4), .CW(2), .DEF_PAT(8'b00_11_10_01)) u_sat (
        .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_sym(in_sym), .clr_cnt(clr_cnt), .match(match2), .match_cnt(match_cnt2),
        .fill(fill2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted symbol; match is checked in the cycle after the accepting edge.
    task automatic feed(input logic [1:0] s, input logic exp_m, input logic clr, input string tag);
        in_valid = 1'b1;
        in_sym   = s;
        clr_cnt  = clr;
        tick();
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        chk(tag, {31'd0, match}, {31'd0, exp_m});
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] m, input logic o,
                       input logic v, input logic [1:0] s);
        cfg_we      = 1'b1;
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_overlap = o;
        in_valid    = v;
        in_sym      = s;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = 8'h00;
        cfg_mask    = 4'h0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        in_sym      = 2'd0;
        clr_cnt     = 1'b0;
        repeat (2) tick();
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
        chk("rst_fill", {28'd0, fill}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Default pattern 1,2,3,0 back to back
        feed(2'd1, 1'b0, 1'b0, "t1_s0");
        chk("t1_fill1", {28'd0, fill}, 32'd1);
        feed(2'd2, 1'b0, 1'b0, "t1_s1");
        feed(2'd3, 1'b0, 1'b0, "t1_s2");
        chk("t1_fill3", {28'd0, fill}, 32'd3);
        feed(2'd0, 1'b1, 1'b0, "t1_s3");
        chk("t1_cnt", {24'd0, match_cnt}, 32'd1);
        chk("t1_fill_flushed", {28'd0, fill}, 32'd0);
        tick();
        chk("t1_pulse_end", {31'd0, match}, 32'd0);

        // All-ones pattern, overlapping
        cfg(8'b01_01_01_01, 4'hF, 1'b1, 1'b0, 2'd0);
        chk("t2_cfg_fill", {28'd0, fill}, 32'd0);
        for (int i = 0; i < 6; i++) feed(2'd1, (i >= 3), 1'b0, "t2_ovl");
        chk("t2_ovl_cnt", {24'd0, match_cnt}, 32'd4);
        chk("t2_ovl_fill", {28'd0, fill}, 32'd4);

        // Same pattern, non-overlapping
        cfg(8'b01_01_01_01, 4'hF, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 8; i++) feed(2'd1, (i == 3 || i == 7), 1'b0, "t2_novl");
        chk("t2_novl_cnt", {24'd0, match_cnt}, 32'd6);

        // Default pattern with 3-cycle gaps between symbols
        cfg(8'b00_11_10_01, 4'hF, 1'b0, 1'b0, 2'd0);
        feed(2'd1, 1'b0, 1'b0, "t3_s0");
        repeat (3) tick();
        chk("t3_gap_fill", {28'd0, fill}, 32'd1);
        feed(2'd2, 1'b0, 1'b0, "t3_s1");
        repeat (3) tick();
        feed(2'd3, 1'b0, 1'b0, "t3_s2");
        repeat (3) tick();
        chk("t3_gap_nomatch", {31'd0, match}, 32'd0);
        feed(2'd0, 1'b1, 1'b0, "t3_s3");
        tick();
        chk("t3_pulse_end", {31'd0, match}, 32'd0);
        chk("t3_cnt", {24'd0, match_cnt}, 32'd7);

        // Symbol 1 is don't-care: pattern 1,x,3,0
        cfg(8'b00_11_00_01, 4'b1101, 1'b0, 1'b0, 2'd0);
        feed(2'd1, 1'b0, 1'b0, "t4_a0");
        feed(2'd2, 1'b0, 1'b0, "t4_a1");
        feed(2'd3, 1'b0, 1'b0, "t4_a2");
        feed(2'd0, 1'b1, 1'b0, "t4_a3");
        feed(2'd1, 1'b0, 1'b0, "t4_b0");
        feed(2'd0, 1'b0, 1'b0, "t4_b1");
        feed(2'd3, 1'b0, 1'b0, "t4_b2");
        feed(2'd0, 1'b1, 1'b0, "t4_b3");
        feed(2'd1, 1'b0, 1'b0, "t4_c0");
        feed(2'd2, 1'b0, 1'b0, "t4_c1");
        feed(2'd2, 1'b0, 1'b0, "t4_c2");
        feed(2'd0, 1'b0, 1'b0, "t4_c3");
        chk("t4_cnt", {24'd0, match_cnt}, 32'd9);
        chk("t4_fill_sat", {28'd0, fill}, 32'd4);

        // Counter saturation (CW=2 instance) and clear-vs-hit priority
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("t5_clr_cnt", {24'd0, match_cnt}, 32'd0);
        chk("t5_clr_cnt2", {30'd0, match_cnt2}, 32'd0);
        cfg(8'b01_01_01_01, 4'hF, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 6; i++) feed(2'd1, (i >= 3), 1'b0, "t5_run");
        chk("t5_cnt2_at3", {30'd0, match_cnt2}, 32'd3);
        feed(2'd1, 1'b1, 1'b0, "t5_hit4");
        feed(2'd1, 1'b1, 1'b0, "t5_hit5");
        chk("t5_cnt2_sat", {30'd0, match_cnt2}, 32'd3);
        chk("t5_cnt_wide", {24'd0, match_cnt}, 32'd5);
        feed(2'd1, 1'b1, 1'b1, "t5_clr_hit_match");
        chk("t5_clr_hit_cnt", {24'd0, match_cnt}, 32'd0);
        chk("t5_clr_hit_cnt2", {30'd0, match_cnt2}, 32'd0);

        // All-zero mask: any 4 accepted symbols hit
        cfg(8'b00_11_10_01, 4'h0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) feed(2'd3, (i == 3), 1'b0, "t5_mask0");
        chk("t5_mask0_cnt", {24'd0, match_cnt}, 32'd1);

        // Mid-sequence reset
        cfg(8'b00_11_10_01, 4'hF, 1'b0, 1'b0, 2'd0);
        feed(2'd1, 1'b0, 1'b0, "t6_s0");
        feed(2'd2, 1'b0, 1'b0, "t6_s1");
        feed(2'd3, 1'b0, 1'b0, "t6_s2");
        reset_n = 1'b0;
        #1;
        chk("t6_async_fill", {28'd0, fill}, 32'd0);
        chk("t6_async_cnt", {24'd0, match_cnt}, 32'd0);
        tick();
        reset_n = 1'b1;
        feed(2'd0, 1'b0, 1'b0, "t6_after_rst");
        chk("t6_fill1", {28'd0, fill}, 32'd1);

        // cfg_we with a valid symbol: symbol dropped and history flushed
        feed(2'd1, 1'b0, 1'b0, "t6_d0");
        feed(2'd2, 1'b0, 1'b0, "t6_d1");
        cfg(8'b00_11_10_01, 4'hF, 1'b0, 1'b1, 2'd3);
        chk("t6_cfg_fill", {28'd0, fill}, 32'd0);
        chk("t6_cfg_nomatch", {31'd0, match}, 32'd0);
        feed(2'd0, 1'b0, 1'b0, "t6_post_cfg");
        chk("t6_post_cfg_fill", {28'd0, fill}, 32'd1);
        chk("t6_final_cnt", {24'd0, match_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
